icache_assoc: RTL

- Parametrised set-associative instruction cache. Replaces the single-word, direct-mapped icache between the datapath fetch stage and the memory arbiter's instruction port.
- Adds multi-word blocks, N-way associativity and a sequential refill FSM that fetches a whole block per miss.
- Adds a one-cycle flush and hit/miss performance counters.

---
 rtl/icache_assoc.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word blocks, a sequential
// block refill FSM, single-cycle flush and saturating hit/miss counters.
module icache_assoc #(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   input  logic             iflush,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int OFF_W  = $clog2(WORDS);
   localparam int WOFF_W = (WORDS > 1) ? OFF_W : 1;
   localparam int IDX_W  = $clog2(SETS);
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int TAG_W  = 30 - OFF_W - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;
   state_t state;

   logic [WAYS-1:0]  valid [SETS];
   logic [WAY_W-1:0] vptr  [SETS];
   logic [TAG_W-1:0] tags  [SETS][WAYS];
   logic [31:0]      data  [SETS][WAYS][WORDS];

   logic [29:0]       waddr;
   logic [WOFF_W-1:0] woff;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;

   assign waddr = imemaddr[31:2];
   assign woff  = WOFF_W'(waddr & 30'(WORDS - 1));
   assign idx   = IDX_W'(waddr >> OFF_W);
   assign tag   = TAG_W'(waddr >> (OFF_W + IDX_W));

   logic [IDX_W-1:0]  f_idx;
   logic [TAG_W-1:0]  f_tag;
   logic [WAY_W-1:0]  f_way;
   logic [WOFF_W-1:0] wcnt;

   logic             hit;
   logic [WAY_W-1:0] hway;
   logic [WAY_W-1:0] vway;

   // Victim: lowest invalid way wins over the round-robin pointer.
   always_comb begin
      hit  = 1'b0;
      hway = '0;
      vway = vptr[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[idx][w] && tags[idx][w] == tag) begin
            hit  = 1'b1;
            hway = WAY_W'(w);
         end
         if (!valid[idx][w]) vway = WAY_W'(w);
      end
   end

   logic miss, accept, last;
   assign ihit     = (state == IDLE) && imemREN && hit && !iflush;
   assign miss     = (state == IDLE) && imemREN && !hit && !iflush;
   assign imemload = data[idx][hway][woff];
   assign accept   = (state == FILL) && !iwait && !iflush;
   assign last     = (wcnt == WOFF_W'(WORDS - 1));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         hit_count  <= '0;
         miss_count <= '0;
         iREN       <= 1'b0;
         iaddr      <= '0;
         wcnt       <= '0;
         f_idx      <= '0;
         f_tag      <= '0;
         f_way      <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            vptr[s]  <= '0;
         end
      end else begin
         if (ihit && hit_count != '1)  hit_count  <= hit_count + 1'b1;
         if (miss && miss_count != '1) miss_count <= miss_count + 1'b1;
         if (iflush) begin
            state <= IDLE;
            wcnt  <= '0;
            iREN  <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
               valid[s] <= '0;
               vptr[s]  <= '0;
            end
         end else begin
            case (state)
               IDLE: if (miss) begin
                  state            <= FILL;
                  f_idx            <= idx;
                  f_tag            <= tag;
                  f_way            <= vway;
                  valid[idx][vway] <= 1'b0;
                  wcnt             <= '0;
                  iREN             <= 1'b1;
                  iaddr            <= imemaddr & ~32'(WORDS * 4 - 1);
               end
               FILL: if (!iwait) begin
                  if (last) begin
                     valid[f_idx][f_way] <= 1'b1;
                     vptr[f_idx]         <= WAY_W'((int'(f_way) + 1) % WAYS);
                     state               <= IDLE;
                     iREN                <= 1'b0;
                     wcnt                <= '0;
                  end else begin
                     wcnt  <= wcnt + 1'b1;
                     iaddr <= iaddr + 32'd4;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Line storage carries no reset; validity alone gates hits.
   always_ff @(posedge CLK) begin
      if (accept) begin
         data[f_idx][f_way][wcnt] <= iload;
         if (last) tags[f_idx][f_way] <= f_tag;
      end
   end
endmodule
